// File: rtl/mms_pkg.sv
// Shared encodings for the MAC Merge verify/respond controller.
// Optional statistics are enabled with MMS_VERIFY_STATS_EN.
package mms_pkg;

   // Verify FSM state encodings
   localparam logic [2:0] ST_INIT_VERIFICATION = 3'd0;
   localparam logic [2:0] ST_VERIFICATION_IDLE = 3'd1;
   localparam logic [2:0] ST_SEND_VERIFY       = 3'd2;
   localparam logic [2:0] ST_WAIT_FOR_RESPONSE = 3'd3;
   localparam logic [2:0] ST_VERIFIED          = 3'd4;
   localparam logic [2:0] ST_VERIFY_FAIL       = 3'd5;

   typedef enum logic [2:0] {
      S_INIT     = ST_INIT_VERIFICATION,
      S_IDLE     = ST_VERIFICATION_IDLE,
      S_SEND     = ST_SEND_VERIFY,
      S_WAIT     = ST_WAIT_FOR_RESPONSE,
      S_VERIFIED = ST_VERIFIED,
      S_FAIL     = ST_VERIFY_FAIL
   } vstate_e;

   // verify_status encodings
   localparam logic [2:0] VS_DISABLED   = 3'd0;
   localparam logic [2:0] VS_INITIAL    = 3'd1;
   localparam logic [2:0] VS_VERIFYING  = 3'd2;
   localparam logic [2:0] VS_SUCCEEDED  = 3'd3;
   localparam logic [2:0] VS_FAILED     = 3'd4;

   localparam logic MPKT_VERIFY  = 1'b0;
   localparam logic MPKT_RESPOND = 1'b1;

   function automatic logic [2:0] status_of(input vstate_e s, input logic p_en,
                                            input logic dis_verify);
      logic [2:0] st;
      st = VS_INITIAL;
      if (dis_verify || !p_en) begin
         st = VS_DISABLED;
      end else begin
         case (s)
            S_INIT, S_IDLE: st = VS_INITIAL;
            S_SEND, S_WAIT: st = VS_VERIFYING;
            S_VERIFIED:     st = VS_SUCCEEDED;
            S_FAIL:         st = VS_FAILED;
            default:        st = VS_INITIAL;
         endcase
      end
      return st;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/mms_verify_arb_ms_timer.sv
// Millisecond verify timer: prescaler plus 8-bit ms down-counter.
// 'expired' is a level that stays high until the next load.
module mms_ms_timer #(
   parameter int CYCLES_PER_MS = 25000,
   parameter int PRESC_W       = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [6:0] load_ms,
   output logic       expired
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CYCLES_PER_MS - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [7:0]         ms_q, ms_d;
   logic               exp_q, exp_d;

   // ms_q == 0 means idle; expiry lands exactly max(load_ms,1)*CYCLES_PER_MS edges after load
   always_comb begin
      presc_d = presc_q;
      ms_d    = ms_q;
      exp_d   = exp_q;
      if (load) begin
         presc_d = PRESC_MAX;
         ms_d    = (load_ms == 7'd0) ? 8'd1 : {1'b0, load_ms};
         exp_d   = 1'b0;
      end else if (ms_q != 8'd0) begin
         if (presc_q == '0) begin
            presc_d = PRESC_MAX;
            ms_d    = ms_q - 8'd1;
            if (ms_q == 8'd1) begin
               exp_d = 1'b1;
            end
         end else begin
            presc_d = presc_q - PRESC_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
         ms_q    <= 8'd0;
         exp_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         ms_q    <= ms_d;
         exp_q   <= exp_d;
      end
   end

   assign expired = exp_q;

endmodule

// File: rtl/mms_verify_arb.sv
// MAC Merge verify/respond controller: verify FSM, retry timer and mPacket arbiter.
// Define MMS_VERIFY_STATS_EN to add saturating transmit/fail counters.
module mms_verify_arb
   import mms_pkg::*;
#(
   parameter int CYCLES_PER_MS = 25000,
   parameter int VERIFY_LIMIT  = 3,
   parameter int PRESC_W       = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p_enable,
   input  logic        disable_verify,
   input  logic        link_fail,
   input  logic [6:0]  verify_time,
   input  logic        rcv_v,
   input  logic        rcv_r,
   // Handshake: a request is accepted in the cycle mpkt_req && mpkt_ack; mpkt_type is
   // held while mpkt_req is high; mpkt_done pulses once when the accepted packet is sent.
   output logic        mpkt_req,
   output logic        mpkt_type,
   input  logic        mpkt_ack,
   input  logic        mpkt_done,
   output logic [2:0]  verify_status,
   output logic        preempt_active,
   output logic [2:0]  dbg_state,
   output logic [2:0]  dbg_verify_cnt
`ifdef MMS_VERIFY_STATS_EN
   ,
   output logic [15:0] stat_verify_tx,
   output logic [15:0] stat_respond_tx,
   output logic [15:0] stat_verify_fail
`endif
);

   localparam logic [2:0] LIMIT = 3'(VERIFY_LIMIT);

   vstate_e    state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       req_q, req_d;
   logic       type_q, type_d;
   logic       busy_q, busy_d;
   logic       busy_type_q, busy_type_d;
   logic       vfy_sent_q, vfy_sent_d;
   logic       pend_q, pend_d;
   logic [2:0] status_q, status_d;
   logic       preempt_q, preempt_d;

   logic override, accept, done_ok, verify_done, verify_want;
   logic tmr_load, tmr_expired;

   assign override = link_fail || !p_enable || disable_verify;
   assign accept   = req_q && mpkt_ack;
   assign done_ok  = mpkt_done && busy_q;
   // vfy_sent_q ties the in-flight verify to the current SEND visit, so a packet
   // accepted before an override cannot advance a later visit
   assign verify_done = done_ok && (busy_type_q == MPKT_VERIFY) && vfy_sent_q
                        && (state_q == S_SEND);
   assign verify_want = (state_q == S_SEND) && !override && !vfy_sent_q;

   mms_ms_timer #(
      .CYCLES_PER_MS (CYCLES_PER_MS),
      .PRESC_W       (PRESC_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .load_ms (verify_time),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmr_load = 1'b0;
      if (override) begin
         state_d = S_INIT;
         cnt_d   = 3'd0;
      end else begin
         case (state_q)
            S_INIT: begin
               cnt_d   = 3'd0;
               state_d = S_IDLE;
            end
            S_IDLE: state_d = S_SEND;
            S_SEND: begin
               if (verify_done) begin
                  cnt_d    = cnt_q + 3'd1;
                  tmr_load = 1'b1;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               if (rcv_r) begin
                  state_d = S_VERIFIED;
               end else if (tmr_expired) begin
                  state_d = (cnt_q < LIMIT) ? S_SEND : S_FAIL;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      req_d       = req_q;
      type_d      = type_q;
      busy_d      = busy_q;
      busy_type_d = busy_type_q;
      if (done_ok) begin
         busy_d = 1'b0;
      end
      if (req_q) begin
         if (mpkt_ack) begin
            req_d       = 1'b0;
            busy_d      = 1'b1;
            busy_type_d = type_q;
         end else if ((type_q == MPKT_VERIFY) && !verify_want) begin
            req_d = 1'b0;
         end
      end else if (!busy_q) begin
         if (pend_q) begin
            req_d  = 1'b1;
            type_d = MPKT_RESPOND;
         end else if (verify_want) begin
            req_d  = 1'b1;
            type_d = MPKT_VERIFY;
         end
      end

      vfy_sent_d = vfy_sent_q;
      if (state_d != S_SEND) begin
         vfy_sent_d = 1'b0;
      end else if (accept && (type_q == MPKT_VERIFY)) begin
         vfy_sent_d = 1'b1;
      end

      // a rcv_v in the respond acceptance cycle re-arms one more response
      pend_d = pend_q;
      if (!p_enable) begin
         pend_d = 1'b0;
      end else if (rcv_v) begin
         pend_d = 1'b1;
      end else if (accept && (type_q == MPKT_RESPOND)) begin
         pend_d = 1'b0;
      end

      status_d  = status_of(state_d, p_enable, disable_verify);
      preempt_d = p_enable && !link_fail && ((status_d == VS_SUCCEEDED) || disable_verify);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         cnt_q       <= 3'd0;
         req_q       <= 1'b0;
         type_q      <= MPKT_VERIFY;
         busy_q      <= 1'b0;
         busy_type_q <= MPKT_VERIFY;
         vfy_sent_q  <= 1'b0;
         pend_q      <= 1'b0;
         status_q    <= VS_INITIAL;
         preempt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         type_q      <= type_d;
         busy_q      <= busy_d;
         busy_type_q <= busy_type_d;
         vfy_sent_q  <= vfy_sent_d;
         pend_q      <= pend_d;
         status_q    <= status_d;
         preempt_q   <= preempt_d;
      end
   end

   assign mpkt_req       = req_q;
   assign mpkt_type      = type_q;
   assign verify_status  = status_q;
   assign preempt_active = preempt_q;
   assign dbg_state      = state_q;
   assign dbg_verify_cnt = cnt_q;

`ifdef MMS_VERIFY_STATS_EN
   logic [15:0] st_vtx_q, st_rtx_q, st_vfail_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_vtx_q   <= 16'd0;
         st_rtx_q   <= 16'd0;
         st_vfail_q <= 16'd0;
      end else begin
         if (done_ok && (busy_type_q == MPKT_VERIFY)) begin
            st_vtx_q <= sat_inc(st_vtx_q);
         end
         if (done_ok && (busy_type_q == MPKT_RESPOND)) begin
            st_rtx_q <= sat_inc(st_rtx_q);
         end
         if ((state_d == S_FAIL) && (state_q != S_FAIL)) begin
            st_vfail_q <= sat_inc(st_vfail_q);
         end
      end
   end

   assign stat_verify_tx   = st_vtx_q;
   assign stat_respond_tx  = st_rtx_q;
   assign stat_verify_fail = st_vfail_q;
`endif

endmodule

// File: tb/tb_mms_verify_arb.sv
// Directed bench for mms_verify_arb with CYCLES_PER_MS=4, VERIFY_LIMIT=3.
// Build with MMS_VERIFY_STATS_EN to also check the statistics counters.
module tb_mms_verify_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       p_enable, disable_verify, link_fail;
   logic [6:0] verify_time;
   logic       rcv_v, rcv_r;
   logic       mpkt_req, mpkt_type, mpkt_ack, mpkt_done;
   logic [2:0] verify_status;
   logic       preempt_active;
   logic [2:0] dbg_state, dbg_verify_cnt;
`ifdef MMS_VERIFY_STATS_EN
   logic [15:0] stat_verify_tx, stat_respond_tx, stat_verify_fail;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mms_verify_arb #(
      .CYCLES_PER_MS (4),
      .VERIFY_LIMIT  (3),
      .PRESC_W       (15)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .p_enable       (p_enable),
      .disable_verify (disable_verify),
      .link_fail      (link_fail),
      .verify_time    (verify_time),
      .rcv_v          (rcv_v),
      .rcv_r          (rcv_r),
      .mpkt_req       (mpkt_req),
      .mpkt_type      (mpkt_type),
      .mpkt_ack       (mpkt_ack),
      .mpkt_done      (mpkt_done),
      .verify_status  (verify_status),
      .preempt_active (preempt_active),
      .dbg_state      (dbg_state),
      .dbg_verify_cnt (dbg_verify_cnt)
`ifdef MMS_VERIFY_STATS_EN
      ,
      .stat_verify_tx   (stat_verify_tx),
      .stat_respond_tx  (stat_respond_tx),
      .stat_verify_fail (stat_verify_fail)
`endif
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      p_enable       = 1'b1;
      disable_verify = 1'b0;
      link_fail      = 1'b0;
      verify_time    = 7'd2;
      rcv_v          = 1'b0;
      rcv_r          = 1'b0;
      mpkt_ack       = 1'b0;
      mpkt_done      = 1'b0;
      tick(1);
   endtask

   // mpkt_req is high now: accept it, then pulse done 'gap' cycles after acceptance
   task automatic xfer(input int gap);
      mpkt_ack = 1'b1;
      tick(1);
      mpkt_ack = 1'b0;
      chk1("req_drop_on_ack", mpkt_req, 1'b0);
      if (gap > 1) tick(gap - 1);
      mpkt_done = 1'b1;
      tick(1);
      mpkt_done = 1'b0;
   endtask

   initial begin
      // ---- 1: verify answered by respond ----
      do_reset();
      chk1("rst_req", mpkt_req, 1'b0);
      chk1("rst_type", mpkt_type, 1'b0);
      chk3("rst_status", verify_status, 3'd1);
      chk1("rst_preempt", preempt_active, 1'b0);
      chk3("rst_state", dbg_state, 3'd0);
      rst_n = 1'b1;
      tick(1);
      chk3("t1_idle", dbg_state, 3'd1);
      chk3("t1_status_init", verify_status, 3'd1);
      tick(1);
      chk3("t1_status_verifying", verify_status, 3'd2);
      chk1("t1_req_not_yet", mpkt_req, 1'b0);
      tick(1);
      chk1("t1_req", mpkt_req, 1'b1);
      chk1("t1_type_verify", mpkt_type, 1'b0);
      xfer(5);
      chk3("t1_wait", dbg_state, 3'd3);
      chk3("t1_cnt1", dbg_verify_cnt, 3'd1);
      tick(2);
      chk1("t1_no_req_in_wait", mpkt_req, 1'b0);
      rcv_r = 1'b1;
      tick(1);
      rcv_r = 1'b0;
      chk3("t1_status_succ", verify_status, 3'd3);
      chk1("t1_preempt", preempt_active, 1'b1);
      tick(10);
      chk1("t1_single_verify", mpkt_req, 1'b0);
      chk3("t1_verified_hold", dbg_state, 3'd4);

      // ---- 2: no response, three retries then fail; timer boundaries ----
      do_reset();
      rst_n = 1'b1;
      tick(3);
      chk1("t2_req1", mpkt_req, 1'b1);
      xfer(5);
      tick(7);
      chk3("t2_r1_wait_d7", dbg_state, 3'd3);
      tick(1);
      chk3("t2_r1_wait_d8", dbg_state, 3'd3);
      tick(1);
      chk3("t2_r1_send_d9", dbg_state, 3'd2);
      tick(1);
      chk1("t2_req2", mpkt_req, 1'b1);
      chk1("t2_req2_type", mpkt_type, 1'b0);
      xfer(5);
      chk3("t2_cnt2", dbg_verify_cnt, 3'd2);
      verify_time = 7'd0;
      tick(8);
      chk3("t2_r2_wait_d8", dbg_state, 3'd3);
      tick(1);
      chk3("t2_r2_send_d9", dbg_state, 3'd2);
      tick(1);
      chk1("t2_req3", mpkt_req, 1'b1);
      xfer(5);
      chk3("t2_cnt3", dbg_verify_cnt, 3'd3);
      tick(4);
      chk3("t2_r3_wait_d4", dbg_state, 3'd3);
      tick(1);
      chk3("t2_fail_state", dbg_state, 3'd5);
      chk3("t2_status_failed", verify_status, 3'd4);
      chk1("t2_preempt_off", preempt_active, 1'b0);
      tick(6);
      chk1("t2_no_4th_req", mpkt_req, 1'b0);
`ifdef MMS_VERIFY_STATS_EN
      chk16("t2_stat_fail", stat_verify_fail, 16'd1);
      chk16("t2_stat_vtx", stat_verify_tx, 16'd3);
`endif

      // ---- 3: coalesced responds behind an in-flight verify ----
      do_reset();
      rst_n = 1'b1;
      tick(3);
      mpkt_ack = 1'b1;
      tick(1);
      mpkt_ack = 1'b0;
      tick(1);
      rcv_v = 1'b1;
      tick(1);
      rcv_v = 1'b0;
      tick(1);
      rcv_v = 1'b1;
      tick(1);
      rcv_v = 1'b0;
      chk1("t3_no_req_while_busy", mpkt_req, 1'b0);
      mpkt_done = 1'b1;
      tick(1);
      mpkt_done = 1'b0;
      chk3("t3_wait", dbg_state, 3'd3);
      chk1("t3_req_after_done_edge", mpkt_req, 1'b0);
      tick(1);
      chk1("t3_resp1_req", mpkt_req, 1'b1);
      chk1("t3_resp1_type", mpkt_type, 1'b1);
      mpkt_ack = 1'b1;
      rcv_v    = 1'b1;
      tick(1);
      mpkt_ack = 1'b0;
      rcv_v    = 1'b0;
      mpkt_done = 1'b1;
      tick(1);
      mpkt_done = 1'b0;
      tick(1);
      chk1("t3_resp2_req", mpkt_req, 1'b1);
      chk1("t3_resp2_type", mpkt_type, 1'b1);
      xfer(1);
      tick(1);
      chk1("t3_no_third_resp", mpkt_req, 1'b0);
      tick(1);
      chk3("t3_still_wait", dbg_state, 3'd3);
      rcv_r = 1'b1;
      tick(1);
      rcv_r = 1'b0;
      chk3("t3_rcv_r_beats_expiry", dbg_state, 3'd4);
`ifdef MMS_VERIFY_STATS_EN
      chk16("t3_stat_rtx", stat_respond_tx, 16'd2);
`endif

      // ---- 4: respond beats verify at the same idle cycle ----
      do_reset();
      rst_n = 1'b1;
      tick(1);
      rcv_v = 1'b1;
      rcv_r = 1'b1;
      tick(1);
      rcv_v = 1'b0;
      rcv_r = 1'b0;
      chk3("t4_rcv_r_ignored", dbg_state, 3'd2);
      tick(1);
      chk1("t4_req", mpkt_req, 1'b1);
      chk1("t4_type_resp", mpkt_type, 1'b1);
      tick(2);
      chk1("t4_req_held", mpkt_req, 1'b1);
      chk1("t4_type_stable", mpkt_type, 1'b1);
      xfer(2);
      tick(1);
      chk1("t4_verify_req", mpkt_req, 1'b1);
      chk1("t4_verify_type", mpkt_type, 1'b0);

      // ---- 5: link_fail in WAIT restarts verification ----
      xfer(5);
      chk3("t5_wait", dbg_state, 3'd3);
      link_fail = 1'b1;
      tick(1);
      chk3("t5_init", dbg_state, 3'd0);
      chk3("t5_cnt0", dbg_verify_cnt, 3'd0);
      chk1("t5_preempt_off", preempt_active, 1'b0);
      tick(1);
      chk3("t5_hold_init", dbg_state, 3'd0);
      link_fail = 1'b0;
      tick(3);
      chk1("t5_fresh_req", mpkt_req, 1'b1);
      chk1("t5_fresh_type", mpkt_type, 1'b0);

      // ---- 6: reset mid-transfer, late done, disable_verify ----
      mpkt_ack = 1'b1;
      tick(1);
      mpkt_ack = 1'b0;
      tick(2);
      rst_n = 1'b0;
      tick(1);
      chk1("t6_rst_req", mpkt_req, 1'b0);
      chk3("t6_rst_status", verify_status, 3'd1);
      chk3("t6_rst_state", dbg_state, 3'd0);
      rst_n          = 1'b1;
      mpkt_done      = 1'b1;
      disable_verify = 1'b1;
      tick(1);
      mpkt_done = 1'b0;
      chk3("t6_status_disabled", verify_status, 3'd0);
      chk1("t6_preempt_dv", preempt_active, 1'b1);
      tick(3);
      chk1("t6_no_verify", mpkt_req, 1'b0);
      chk3("t6_stay_init", dbg_state, 3'd0);
`ifdef MMS_VERIFY_STATS_EN
      chk16("t6_late_done_ignored", stat_verify_tx, 16'd0);
`endif
      disable_verify = 1'b0;
      tick(3);
      chk1("t6_req_again", mpkt_req, 1'b1);
      disable_verify = 1'b1;
      tick(1);
      chk1("t6_req_dropped", mpkt_req, 1'b0);
      chk3("t6_status_dis2", verify_status, 3'd0);
      link_fail = 1'b1;
      tick(1);
      chk1("t6_preempt_linkfail", preempt_active, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
